// File: rtl/i2c_seq_ctrl.sv
// Register-level sequencer for a Wishbone I2C master core: init, then single-byte register write/read.
// Optional poll watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_seq_ctrl #(
  parameter logic [15:0] PRESCALE       = 16'd49,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req_i,
  input  logic       rnw_i,
  input  logic [6:0] dev_i,
  input  logic [7:0] reg_i,
  input  logic [7:0] wdata_i,
  output logic       ready_o,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic       nack_o,
  output logic       err_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i,
  output logic [3:0] dbg_state_o
);

  // Command handshake: a command is taken on any clock edge where req_i and ready_o are both 1.
  // ready_o is high only in IDLE, so requests during a sequence or the done_o cycle are ignored.

  typedef enum logic [3:0] {
    INIT_PRLO = 4'd0,
    INIT_PRHI = 4'd1,
    INIT_CTR  = 4'd2,
    IDLE      = 4'd3,
    WR_TXR    = 4'd4,
    WR_CR     = 4'd5,
    POLL_SR   = 4'd6,
    RD_RXR    = 4'd7,
    STOP      = 4'd8,
    DONE      = 4'd9
  } state_t;

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;

  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  state_t      state_q, state_d;
  logic        cyc_q, we_q;
  logic [2:0]  adr_q;
  logic [7:0]  dat_q;
  logic        acc_req, acc_we;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_dat;
  logic        bus_done;
  logic        tmo_hit;

  logic        rnw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wdata_q;
  logic [1:0]  step_q;
  logic        stop_phase_q;
  logic [7:0]  rdata_q;
  logic        nack_q, err_q;

  logic        accept, set_err, set_nack, step_inc, set_stop, load_rdata;
  logic [7:0]  txr_byte, cr_byte;
  logic        last_rd, last_wr;

  assign bus_done = cyc_q & wbm_ack_i;
  assign last_rd  = rnw_q & (step_q == 2'd3);
  assign last_wr  = ~rnw_q & (step_q == 2'd2);

  always_comb begin
    txr_byte = 8'h00;
    cr_byte  = 8'h00;
    case (step_q)
      2'd0: begin txr_byte = {dev_q, 1'b0}; cr_byte = 8'h90; end
      2'd1: begin txr_byte = reg_q;         cr_byte = 8'h10; end
      2'd2: begin
        txr_byte = rnw_q ? {dev_q, 1'b1} : wdata_q;
        cr_byte  = rnw_q ? 8'h90 : 8'h50;
      end
      default: cr_byte = 8'h68;
    endcase
  end

`ifdef I2C_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  assign tmo_hit = (tmo_cnt_q >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_cnt_q <= 32'd0;
    end else if (state_q != POLL_SR) begin
      tmo_cnt_q <= 32'd0;
    end else if (!tmo_hit) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= INIT_PRLO;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    acc_req    = 1'b0;
    acc_we     = 1'b0;
    acc_adr    = 3'd0;
    acc_dat    = 8'h00;
    accept     = 1'b0;
    set_err    = 1'b0;
    set_nack   = 1'b0;
    step_inc   = 1'b0;
    set_stop   = 1'b0;
    load_rdata = 1'b0;
    case (state_q)
      INIT_PRLO: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_PRERLO; acc_dat = PRESCALE[7:0];
        if (bus_done) state_d = INIT_PRHI;
      end
      INIT_PRHI: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_PRERHI; acc_dat = PRESCALE[15:8];
        if (bus_done) state_d = INIT_CTR;
      end
      INIT_CTR: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CTR; acc_dat = 8'h80;
        if (bus_done) state_d = IDLE;
      end
      IDLE: begin
        if (req_i) begin
          accept  = 1'b1;
          state_d = WR_TXR;
        end
      end
      WR_TXR: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_TXR; acc_dat = txr_byte;
        if (bus_done) state_d = WR_CR;
      end
      WR_CR: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CR; acc_dat = cr_byte;
        if (bus_done) state_d = POLL_SR;
      end
      POLL_SR: begin
        // Once the watchdog fires, no new poll is launched; an in-flight one finishes first.
        acc_req = ~tmo_hit; acc_adr = ADR_CR;
        if (tmo_hit && (!cyc_q || bus_done)) begin
          set_err = 1'b1;
          state_d = DONE;
        end else if (bus_done && !wbm_dat_i[SR_TIP]) begin
          if (wbm_dat_i[SR_AL]) begin
            set_err = 1'b1;
            state_d = DONE;
          end else if (stop_phase_q) begin
            state_d = DONE;
          end else if (last_rd) begin
            state_d = RD_RXR;
          end else if (wbm_dat_i[SR_RXACK]) begin
            set_nack = 1'b1;
            state_d  = STOP;
          end else if (last_wr) begin
            state_d = DONE;
          end else begin
            step_inc = 1'b1;
            // The final read byte has no TXR load, only the CR command.
            state_d  = (rnw_q && step_q == 2'd2) ? WR_CR : WR_TXR;
          end
        end
      end
      RD_RXR: begin
        acc_req = 1'b1; acc_adr = ADR_TXR;
        if (bus_done) begin
          load_rdata = 1'b1;
          state_d    = DONE;
        end
      end
      STOP: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = ADR_CR; acc_dat = 8'h40;
        if (bus_done) begin
          set_stop = 1'b1;
          state_d  = POLL_SR;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = INIT_PRLO;
    endcase
  end

  // Bus cycles launch only from a dropped bus, so every ack is followed by at least one idle cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= 3'd0;
      dat_q <= 8'h00;
    end else if (cyc_q) begin
      if (wbm_ack_i) begin
        cyc_q <= 1'b0;
        we_q  <= 1'b0;
      end
    end else if (acc_req) begin
      cyc_q <= 1'b1;
      we_q  <= acc_we;
      adr_q <= acc_adr;
      dat_q <= acc_dat;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rnw_q        <= 1'b0;
      dev_q        <= 7'd0;
      reg_q        <= 8'h00;
      wdata_q      <= 8'h00;
      step_q       <= 2'd0;
      stop_phase_q <= 1'b0;
      rdata_q      <= 8'h00;
      nack_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        rnw_q        <= rnw_i;
        dev_q        <= dev_i;
        reg_q        <= reg_i;
        wdata_q      <= wdata_i;
        step_q       <= 2'd0;
        stop_phase_q <= 1'b0;
        nack_q       <= 1'b0;
        err_q        <= 1'b0;
      end
      if (step_inc)   step_q       <= step_q + 2'd1;
      if (set_stop)   stop_phase_q <= 1'b1;
      if (set_nack)   nack_q       <= 1'b1;
      if (set_err)    err_q        <= 1'b1;
      if (load_rdata) rdata_q      <= wbm_dat_i;
    end
  end

  assign ready_o     = (state_q == IDLE);
  assign done_o      = (state_q == DONE);
  assign rdata_o     = rdata_q;
  assign nack_o      = nack_q;
  assign err_o       = err_q;
  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = cyc_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/i2c_seq_ctrl.md
I2C_SEQ_CTRL -- requirements
Module: i2c_seq_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'd49, the SCL prescale value written to the I2C master core at init.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, the poll watchdog limit (used only when I2C_SEQ_TIMEOUT_EN is defined).
REQ-003 SHALL have ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  command request.
- rnw_i  in  1  1=register read, 0=register write.
- dev_i  in  7  I2C device address.
- reg_i  in  8  device register address.
- wdata_i  in  8  write data.
- ready_o  out  1  idle and accepting a command.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  8  read data.
- nack_o  out  1  device NACK seen.
- err_o  out  1  arbitration lost or timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls to the I2C core.
- wbm_adr_o  out  3  core register index.
- wbm_dat_o  out  8  write data to the core.
- wbm_dat_i  in  8  read data from the core.
- wbm_ack_i  in  1  Wishbone acknowledge.

Function
REQ-004 SHALL use core register indices PRERlo=0, PRERhi=1, CTR=2, TXR/RXR=3, CR/SR=4.
REQ-005 SHALL use CR bits STA=7, STO=6, RD=5, WR=4, ACK=3, and SR bits RxACK=7, AL=5, TIP=1.
REQ-006 SHALL perform each core access as one classic cycle: cyc/stb/we/adr/dat held stable until wbm_ack_i, then dropped for at least one cycle.
REQ-007 SHALL, after reset, write PRERlo=PRESCALE[7:0], then PRERhi=PRESCALE[15:8], then CTR=8'h80, then enter IDLE; ready_o SHALL be 0 until then.
REQ-008 SHALL drive ready_o=1 only in IDLE, and SHALL accept a command when req_i and ready_o are both 1, capturing rnw_i, dev_i, reg_i and wdata_i.
REQ-009 SHALL implement the write sequence as:
- TXR={dev,0}, CR=0x90.
- TXR=reg, CR=0x10.
- TXR=wdata, CR=0x50.
REQ-010 SHALL implement the read sequence as:
- TXR={dev,0}, CR=0x90.
- TXR=reg, CR=0x10.
- TXR={dev,1}, CR=0x90.
- CR=0x68, then read RXR into rdata_o.
REQ-011 SHALL, after every CR write, poll SR repeatedly until TIP=0.
REQ-012 SHALL have states INIT_PRLO, INIT_PRHI, INIT_CTR, IDLE, WR_TXR, WR_CR, POLL_SR, RD_RXR, STOP, DONE.
REQ-013 SHALL, when a poll completes with AL=1, set err_o=1 and go directly to DONE without issuing STOP.
REQ-014 SHALL, when a poll completes with RxACK=1 on any address or write byte, set nack_o=1, write CR=0x40, poll until TIP=0, then go to DONE.
REQ-015 SHALL ignore RxACK after the final read byte.
REQ-016 SHALL pulse done_o for exactly one cycle in DONE, then return to IDLE.
REQ-017 SHALL hold rdata_o, nack_o and err_o stable from done_o until the next accepted command, and SHALL clear nack_o and err_o on acceptance.
REQ-018 SHALL leave rdata_o unchanged for write commands and for aborted reads.
REQ-019 SHALL ignore req_i when not in IDLE, including the done_o cycle.

Reset
REQ-020 SHALL, when rst_ni is low, immediately force state INIT_PRLO and all outputs to 0 (rdata_o=8'h00), regardless of any bus cycle in progress.
REQ-021 SHALL, on release of rst_ni, restart the init sequence from INIT_PRLO.

Configuration
REQ-022 SHALL, with I2C_SEQ_TIMEOUT_EN defined, count cycles spent in POLL_SR per CR write.
REQ-023 SHALL, with I2C_SEQ_TIMEOUT_EN defined, abort to DONE with err_o=1 when that count reaches TIMEOUT_CYCLES, dropping cyc/stb at the next acknowledge.
REQ-024 SHALL, without I2C_SEQ_TIMEOUT_EN, include no watchdog logic and poll indefinitely.

Verification
REQ-025 Reset release with a zero-wait core model -> writes 0x31@0, 0x00@1, 0x80@2 in order, then ready_o=1.
REQ-026 Write dev=0x50, reg=0x10, data=0xA5 with device ACKs -> TXR 0xA0/0x10/0xA5, CR 0x90/0x10/0x50, done_o pulse, nack_o=0, err_o=0.
REQ-027 Read dev=0x50, reg=0x02, slave returns 0x3C -> TXR 0xA0/0x02/0xA1, final CR=0x68, rdata_o=0x3C, done_o pulse.
REQ-028 Write with RxACK=1 on the address byte -> CR=0x40 issued, nack_o=1, no further TXR writes.
REQ-029 SR returns AL=1 -> err_o=1 and done_o with no STOP written; with I2C_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=100, TIP held at 1 -> err_o=1 within 100 cycles plus one access.
REQ-030 rst_ni asserted mid-poll -> cyc/stb=0 immediately, and the init sequence is re-run after release.
